// File: rtl/p405s_dcu_taginvalseq.sv
// rtl/p405s_dcu_taginvalseq.sv - DCU tag invalidate sequencer: clears valid bits over a wrapping class range.
// Optional write/read-back verification enabled by defining P405S_DCU_INVAL_VERIFY_EN.
module p405s_dcu_taginvalseq (
   input  logic       CB,
   input  logic       reset,
   input  logic       invStart,
   input  logic [7:0] invStartIdx,
   input  logic [7:0] invEndIdx,
   input  logic [1:0] invWayMask,
   input  logic       invAbort,
   input  logic       coreTagReq,
   input  logic       validA,
   input  logic       validB,
   output logic [9:0] tagIndex,
   output logic       tagReadWriteCycle_In,
   output logic       tagReadNotWrite_In,
   output logic       writeTagA0,
   output logic       writeTagB0,
   output logic       newValidIn,
   output logic       invBusy,
   output logic       invDone,
   output logic       invAbortAck,
   output logic       invErr
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_DONE  = 3'd2;
`ifdef P405S_DCU_INVAL_VERIFY_EN
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
`endif

   logic [2:0] state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] end_q, end_d;
   logic [1:0] mask_q, mask_d;
   logic       ack_q, ack_d;
`ifdef P405S_DCU_INVAL_VERIFY_EN
   logic       err_q, err_d;
`endif

   // Move to the next class, or finish once the inclusive end class is done.
   function automatic void advance(input logic [7:0] idx, input logic [7:0] last,
                                   output logic [2:0] nstate, output logic [7:0] nidx);
      nstate = S_WRITE;
      nidx   = idx;
      if (idx == last) begin
         nstate = S_DONE;
      end else begin
         nidx = idx + 8'd1;
      end
   endfunction

   always_comb begin
      state_d              = state_q;
      idx_d                = idx_q;
      end_d                = end_q;
      mask_d               = mask_q;
      ack_d                = 1'b0;
`ifdef P405S_DCU_INVAL_VERIFY_EN
      err_d                = err_q;
`endif
      tagReadWriteCycle_In = 1'b0;
      tagReadNotWrite_In   = 1'b1;
      writeTagA0           = 1'b0;
      writeTagB0           = 1'b0;
      tagIndex             = 10'd0;

      case (state_q)
         S_IDLE: begin
            if (invStart) begin
               idx_d   = invStartIdx;
               end_d   = invEndIdx;
               mask_d  = invWayMask;
`ifdef P405S_DCU_INVAL_VERIFY_EN
               err_d   = 1'b0;
`endif
               state_d = (invWayMask == 2'b00) ? S_DONE : S_WRITE;
            end
         end
         S_WRITE: begin
            if (invAbort) begin
               state_d = S_IDLE;
               ack_d   = 1'b1;
            end else if (!coreTagReq) begin
               tagReadWriteCycle_In = 1'b1;
               tagReadNotWrite_In   = 1'b0;
               writeTagA0           = mask_q[0];
               writeTagB0           = mask_q[1];
               tagIndex             = {1'b0, idx_q, 1'b0};
`ifdef P405S_DCU_INVAL_VERIFY_EN
               state_d = S_READ;
`else
               advance(idx_q, end_q, state_d, idx_d);
`endif
            end
         end
`ifdef P405S_DCU_INVAL_VERIFY_EN
         S_READ: begin
            if (invAbort) begin
               state_d = S_IDLE;
               ack_d   = 1'b1;
            end else if (!coreTagReq) begin
               tagReadWriteCycle_In = 1'b1;
               tagIndex             = {1'b0, idx_q, 1'b0};
               state_d              = S_CHECK;
            end
         end
         S_CHECK: begin
            if (invAbort) begin
               state_d = S_IDLE;
               ack_d   = 1'b1;
            end else begin
               // Any surviving valid bit in a masked way means the write did not take.
               if ((mask_q[0] & validA) | (mask_q[1] & validB)) begin
                  err_d = 1'b1;
               end
               advance(idx_q, end_q, state_d, idx_d);
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
            ack_d   = invAbort;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CB) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= 8'd0;
         end_q   <= 8'd0;
         mask_q  <= 2'b00;
         ack_q   <= 1'b0;
`ifdef P405S_DCU_INVAL_VERIFY_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         end_q   <= end_d;
         mask_q  <= mask_d;
         ack_q   <= ack_d;
`ifdef P405S_DCU_INVAL_VERIFY_EN
         err_q   <= err_d;
`endif
      end
   end

   assign newValidIn  = 1'b0;
   assign invBusy     = (state_q != S_IDLE);
   assign invDone     = (state_q == S_DONE) & ~invAbort;
   assign invAbortAck = ack_q;
`ifdef P405S_DCU_INVAL_VERIFY_EN
   assign invErr      = err_q;
`else
   assign invErr      = 1'b0;
   wire   unused_valid = &{1'b0, validA, validB};
`endif

endmodule

// File: tb/tb_p405s_dcu_taginvalseq.sv
// tb/tb_p405s_dcu_taginvalseq.sv - directed bench for the tag invalidate sequencer.
module tb_p405s_dcu_taginvalseq;

   logic       CB = 1'b0;
   logic       reset = 1'b1;
   logic       invStart = 1'b0;
   logic [7:0] invStartIdx = 8'd0;
   logic [7:0] invEndIdx = 8'd0;
   logic [1:0] invWayMask = 2'b00;
   logic       invAbort = 1'b0;
   logic       coreTagReq = 1'b0;
   logic       validA = 1'b0;
   logic       validB = 1'b0;
   logic [9:0] tagIndex;
   logic       tagReadWriteCycle_In, tagReadNotWrite_In;
   logic       writeTagA0, writeTagB0, newValidIn;
   logic       invBusy, invDone, invAbortAck, invErr;

   int n_checks = 0;
   int n_errors = 0;

   p405s_dcu_taginvalseq dut (
      .CB(CB), .reset(reset), .invStart(invStart), .invStartIdx(invStartIdx),
      .invEndIdx(invEndIdx), .invWayMask(invWayMask), .invAbort(invAbort),
      .coreTagReq(coreTagReq), .validA(validA), .validB(validB),
      .tagIndex(tagIndex), .tagReadWriteCycle_In(tagReadWriteCycle_In),
      .tagReadNotWrite_In(tagReadNotWrite_In), .writeTagA0(writeTagA0),
      .writeTagB0(writeTagB0), .newValidIn(newValidIn), .invBusy(invBusy),
      .invDone(invDone), .invAbortAck(invAbortAck), .invErr(invErr)
   );

   always #5 CB = ~CB;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CB);
      #1;
   endtask

   task automatic expect_quiet(input string tag);
      chk({tag, "_rw"}, tagReadWriteCycle_In, 1'b0);
      chk({tag, "_rnw"}, tagReadNotWrite_In, 1'b1);
      chk({tag, "_strb"}, {writeTagA0, writeTagB0}, 2'b00);
      chk({tag, "_idx"}, tagIndex, 10'd0);
   endtask

   // One class: write cycle; with verification also a read and a check cycle.
   task automatic do_class(input string tag, input logic [7:0] idx, input logic [1:0] m,
                           input logic va);
      @(negedge CB);
      chk({tag, "_w_rw"}, tagReadWriteCycle_In, 1'b1);
      chk({tag, "_w_rnw"}, tagReadNotWrite_In, 1'b0);
      chk({tag, "_w_a"}, writeTagA0, m[0]);
      chk({tag, "_w_b"}, writeTagB0, m[1]);
      chk({tag, "_w_idx"}, tagIndex, {1'b0, idx, 1'b0});
      chk({tag, "_w_nv"}, newValidIn, 1'b0);
      chk({tag, "_w_busy"}, invBusy, 1'b1);
      tick();
`ifdef P405S_DCU_INVAL_VERIFY_EN
      @(negedge CB);
      chk({tag, "_r_rw"}, tagReadWriteCycle_In, 1'b1);
      chk({tag, "_r_rnw"}, tagReadNotWrite_In, 1'b1);
      chk({tag, "_r_strb"}, {writeTagA0, writeTagB0}, 2'b00);
      chk({tag, "_r_idx"}, tagIndex, {1'b0, idx, 1'b0});
      tick();
      validA = va;
      @(negedge CB);
      expect_quiet({tag, "_c"});
      tick();
      validA = 1'b0;
`else
      validA = va;
      validA = 1'b0;
`endif
   endtask

   task automatic start_seq(input logic [7:0] s, input logic [7:0] e, input logic [1:0] m);
      invStart    = 1'b1;
      invStartIdx = s;
      invEndIdx   = e;
      invWayMask  = m;
      tick();
      invStart = 1'b0;
   endtask

   task automatic expect_done(input string tag);
      @(negedge CB);
      chk({tag, "_done"}, invDone, 1'b1);
      chk({tag, "_done_busy"}, invBusy, 1'b1);
      expect_quiet({tag, "_done"});
      tick();
      @(negedge CB);
      chk({tag, "_after_done"}, invDone, 1'b0);
      chk({tag, "_after_busy"}, invBusy, 1'b0);
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      @(negedge CB);
      chk("rst_busy", invBusy, 1'b0);
      chk("rst_done", invDone, 1'b0);
      chk("rst_ack", invAbortAck, 1'b0);
      chk("rst_err", invErr, 1'b0);
      expect_quiet("rst");

      // four consecutive classes, both ways
      tick();
      start_seq(8'h10, 8'h13, 2'b11);
      for (int i = 0; i < 4; i++) do_class("seq", 8'h10 + 8'(i), 2'b11, 1'b0);
      expect_done("seq");
      chk("seq_err", invErr, 1'b0);

      // class index wraps 0xFF -> 0x00, way A only
      tick();
      start_seq(8'hFE, 8'h01, 2'b01);
      do_class("wrap_fe", 8'hFE, 2'b01, 1'b0);
      do_class("wrap_ff", 8'hFF, 2'b01, 1'b0);
      do_class("wrap_00", 8'h00, 2'b01, 1'b0);
      do_class("wrap_01", 8'h01, 2'b01, 1'b0);
      expect_done("wrap");

      // core stalls the write of 0x11 for three cycles
      tick();
      start_seq(8'h10, 8'h13, 2'b11);
      do_class("stl_10", 8'h10, 2'b11, 1'b0);
      coreTagReq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CB);
         expect_quiet("stall");
         chk("stall_busy", invBusy, 1'b1);
         tick();
      end
      coreTagReq = 1'b0;
      do_class("stl_11", 8'h11, 2'b11, 1'b0);
      do_class("stl_12", 8'h12, 2'b11, 1'b0);
      do_class("stl_13", 8'h13, 2'b11, 1'b0);
      expect_done("stall");

      // abort after the second class of a full sweep
      tick();
      start_seq(8'h00, 8'hFF, 2'b11);
      do_class("abt_00", 8'h00, 2'b11, 1'b0);
      do_class("abt_01", 8'h01, 2'b11, 1'b0);
      invAbort = 1'b1;
      @(negedge CB);
      expect_quiet("abt_cyc");
      chk("abt_cyc_done", invDone, 1'b0);
      tick();
      invAbort = 1'b0;
      @(negedge CB);
      chk("abt_ack", invAbortAck, 1'b1);
      chk("abt_busy", invBusy, 1'b0);
      chk("abt_done", invDone, 1'b0);
      tick();
      @(negedge CB);
      chk("abt_ack_pulse", invAbortAck, 1'b0);
      chk("abt_done2", invDone, 1'b0);

      // abort while idle does nothing
      invAbort = 1'b1;
      tick();
      invAbort = 1'b0;
      @(negedge CB);
      chk("idle_abt_ack", invAbortAck, 1'b0);

      // reset in the middle of a run
      tick();
      start_seq(8'h00, 8'hFF, 2'b11);
      do_class("rmid_00", 8'h00, 2'b11, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge CB);
      chk("rmid_busy", invBusy, 1'b0);
      chk("rmid_ack", invAbortAck, 1'b0);
      chk("rmid_done", invDone, 1'b0);
      expect_quiet("rmid");
      tick();
      @(negedge CB);
      chk("rmid_ack2", invAbortAck, 1'b0);
      chk("rmid_done2", invDone, 1'b0);

      // reset wins over a simultaneous start
      reset    = 1'b1;
      invStart = 1'b1;
      tick();
      reset    = 1'b0;
      invStart = 1'b0;
      @(negedge CB);
      chk("rprio_busy", invBusy, 1'b0);

      // empty way mask: straight to done
      tick();
      start_seq(8'h20, 8'h30, 2'b00);
      expect_done("mask0");

      // single class, way B; start requests while busy are ignored
      tick();
      start_seq(8'h7F, 8'h7F, 2'b10);
      invStart    = 1'b1;
      invStartIdx = 8'h20;
      do_class("one_7f", 8'h7F, 2'b10, 1'b0);
      invStart = 1'b0;
      expect_done("one");

`ifdef P405S_DCU_INVAL_VERIFY_EN
      // valid bit survives the write of 0x05
      tick();
      start_seq(8'h04, 8'h06, 2'b01);
      do_class("ver_04", 8'h04, 2'b01, 1'b0);
      chk("ver_err0", invErr, 1'b0);
      do_class("ver_05", 8'h05, 2'b01, 1'b1);
      @(negedge CB);
      chk("ver_err_set", invErr, 1'b1);
      do_class("ver_06", 8'h06, 2'b01, 1'b0);
      @(negedge CB);
      chk("ver_err_done", invErr, 1'b1);
      expect_done("ver");
      chk("ver_err_idle", invErr, 1'b1);
      start_seq(8'h00, 8'h00, 2'b00);
      @(negedge CB);
      chk("ver_err_clr", invErr, 1'b0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
